// File: rtl/mmio_io_pkg.sv
// Shared offset map, CTRL bit positions and window geometry for the MMIO I/O bank.
package mmio_io_pkg;

  localparam int unsigned WIN_W = 8;

  localparam logic [WIN_W-1:0] OFF_IN    = 8'h00;
  localparam logic [WIN_W-1:0] OFF_OUT   = 8'h10;
  localparam logic [WIN_W-1:0] OFF_CHG   = 8'h20;
  localparam logic [WIN_W-1:0] OFF_TIMER = 8'h21;
  localparam logic [WIN_W-1:0] OFF_CMP   = 8'h22;
  localparam logic [WIN_W-1:0] OFF_CTRL  = 8'h23;
  localparam logic [WIN_W-1:0] OFF_IRQ   = 8'h24;

  localparam int unsigned CTRL_W          = 3;
  localparam int unsigned CTRL_TIMER_EN   = 0;
  localparam int unsigned CTRL_IRQ_TMR_EN = 1;
  localparam int unsigned CTRL_IRQ_CHG_EN = 2;

endpackage

// File: rtl/io_sync_edge.sv
// One input channel: two-flop synchroniser plus previous-value register; chg_o
// is high for the single cycle in which a new synchronised value first appears.
module io_sync_edge #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o,
  output logic              chg_o
);

  logic [DATA_W-1:0] meta_q, sync_q, prev_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign q_o   = sync_q;
  assign chg_o = (sync_q != prev_q);

endmodule

// File: rtl/mmio_io_bank.sv
// Memory-mapped I/O bank beside the data RAM: synchronised inputs with change
// flags, output registers, a prescaled tick timer with compare, and one irq.
module mmio_io_bank
  import mmio_io_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 12,
  parameter int unsigned       NUM_IN   = 2,
  parameter int unsigned       NUM_OUT  = 2,
  parameter logic [ADDR_W-1:0] BASE     = 12'hF00,
  parameter int unsigned       TICK_DIV = 50000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      wren,
  input  logic [ADDR_W-1:0]         address,
  input  logic [DATA_W-1:0]         data,
  output logic                      sel,
  output logic [DATA_W-1:0]         q,
  input  logic [NUM_IN*DATA_W-1:0]  in_ch,
  output logic [NUM_OUT*DATA_W-1:0] out_ch,
  output logic                      irq
);

  localparam int unsigned PRE_W = $clog2(TICK_DIV);

  logic [WIN_W-1:0] off;
  logic             wr;

  logic [NUM_IN-1:0][DATA_W-1:0]  in_val;
  logic [NUM_IN-1:0]              chg_pulse;
  logic [NUM_OUT-1:0][DATA_W-1:0] out_q, out_d;
  logic [NUM_IN-1:0]              chg_q, chg_d;
  logic [DATA_W-1:0]              timer_q, timer_d, cmp_q, cmp_d, q_q, q_d, rdata;
  logic [PRE_W-1:0]               presc_q, presc_d;
  logic [CTRL_W-1:0]              ctrl_q, ctrl_d;
  logic                           stat_q, stat_d, irq_q, irq_d, match;

  assign off    = address[WIN_W-1:0];
  assign sel    = (address[ADDR_W-1:WIN_W] == BASE[ADDR_W-1:WIN_W]);
  assign wr     = wren & sel;
  assign out_ch = out_q;
  assign q      = q_q;
  assign irq    = irq_q;

  for (genvar g = 0; g < NUM_IN; g++) begin : g_in
    io_sync_edge #(.DATA_W(DATA_W)) u_sync (
      .clock (clock),
      .reset (reset),
      .d_i   (in_ch[g*DATA_W +: DATA_W]),
      .q_o   (in_val[g]),
      .chg_o (chg_pulse[g])
    );
  end

  always_comb begin
    out_d = out_q;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      if (wr && off == WIN_W'(OFF_OUT + i)) out_d[i] = data;
    end
    // new changes are ORed in after the clear so a same-cycle set survives W1C
    chg_d  = (chg_q & ~((wr && off == OFF_CHG) ? data[NUM_IN-1:0] : '0)) | chg_pulse;
    cmp_d  = (wr && off == OFF_CMP) ? data : cmp_q;
    ctrl_d = (wr && off == OFF_CTRL) ? data[CTRL_W-1:0] : ctrl_q;
  end

  always_comb begin
    timer_d = timer_q;
    presc_d = presc_q;
    match   = 1'b0;
    if (wr && off == OFF_TIMER) begin
      timer_d = data;
      presc_d = '0;
    end else if (ctrl_q[CTRL_TIMER_EN]) begin
      if (presc_q == PRE_W'(TICK_DIV - 1)) begin
        presc_d = '0;
        timer_d = timer_q + 1'b1;
        match   = (timer_d == cmp_q);
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
    stat_d = (stat_q & ~(wr && off == OFF_IRQ && data[0])) | match;
    irq_d  = (stat_q & ctrl_q[CTRL_IRQ_TMR_EN]) | ((|chg_q) & ctrl_q[CTRL_IRQ_CHG_EN]);
  end

  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (off == WIN_W'(OFF_IN + i)) rdata = in_val[i];
    end
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      if (off == WIN_W'(OFF_OUT + i)) rdata = out_q[i];
    end
    case (off)
      OFF_CHG:   rdata[NUM_IN-1:0] = chg_q;
      OFF_TIMER: rdata = timer_q;
      OFF_CMP:   rdata = cmp_q;
      OFF_CTRL:  rdata[CTRL_W-1:0] = ctrl_q;
      OFF_IRQ:   rdata[0] = stat_q;
      default:   ;
    endcase
    q_d = sel ? rdata : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_q   <= '0;
      chg_q   <= '0;
      timer_q <= '0;
      presc_q <= '0;
      cmp_q   <= '0;
      ctrl_q  <= '0;
      stat_q  <= 1'b0;
      q_q     <= '0;
      irq_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      chg_q   <= chg_d;
      timer_q <= timer_d;
      presc_q <= presc_d;
      cmp_q   <= cmp_d;
      ctrl_q  <= ctrl_d;
      stat_q  <= stat_d;
      q_q     <= q_d;
      irq_q   <= irq_d;
    end
  end

endmodule
